// File: rtl/fnd_pkg.sv
// Shared constants, glyph table and state type for the FND display blocks.
package fnd_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic       COM_OFF = 1'b1;

  // Active-high {g,f,e,d,c,b,a} glyphs for hex digits 0..F.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } scan_state_e;

  // True for a digit that shows plain zero with its decimal point off.
  function automatic logic is_zero_digit(input logic [4:0] digit);
    return (digit == 5'd0);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex value plus decimal point to active-high {dp,g,f,e,d,c,b,a} segments.
module seg7_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] value,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {dp, HEX_GLYPH[value]};

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed common-anode FND scanner with blank slots, frame-synchronous
// double-buffered digit values and leading-zero blanking.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 100_000,
  parameter int BLANK_CYC  = 1_000,
  parameter int ADDR_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_en,
  input  logic                  i_lzb,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [4:0]            i_wr_data,
  output logic [NUM_DIGITS-1:0] o_com,
  output logic [7:0]            o_seg,
  output logic                  o_frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(TICK_DIV);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  scan_state_e           state_r, state_next_s;
  logic [CNT_W-1:0]      cnt_r, cnt_next_s;
  logic [IDX_W-1:0]      idx_r, idx_next_s;
  logic [4:0]            shadow_r [NUM_DIGITS];
  logic [4:0]            disp_r   [NUM_DIGITS];
  logic                  commit_s, frame_end_s, wr_hit_s, blank_run_s;
  logic [IDX_W-1:0]      wr_idx_s;
  logic [NUM_DIGITS-1:0] lzb_mask_s, com_s;
  logic [7:0]            seg_hi_s, seg_s;
  logic [4:0]            cur_digit_s;

  assign wr_hit_s    = i_wr_en && (32'(i_wr_addr) < 32'(NUM_DIGITS));
  assign wr_idx_s    = i_wr_addr[IDX_W-1:0];
  assign cur_digit_s = disp_r[idx_r];

  seg7_decoder u_seg7_decoder (
    .value (cur_digit_s[3:0]),
    .dp    (cur_digit_s[4]),
    .seg   (seg_hi_s)
  );

  // State register with slot counter and digit index
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= S_OFF;
      cnt_r   <= '0;
      idx_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      idx_r   <= idx_next_s;
    end
  end

  // Next-state, slot timing and commit decisions; disabling wins over everything
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    idx_next_s   = idx_r;
    commit_s     = 1'b0;
    frame_end_s  = 1'b0;
    if (!i_en) begin
      state_next_s = S_OFF;
      cnt_next_s   = '0;
      idx_next_s   = '0;
    end else begin
      case (state_r)
        S_OFF: begin
          state_next_s = S_BLANK;
          cnt_next_s   = '0;
          idx_next_s   = '0;
          commit_s     = 1'b1;
        end
        S_BLANK: begin
          cnt_next_s = cnt_r + CNT_ONE;
          if (cnt_r == BLANK_LAST) begin
            state_next_s = S_ON;
          end else begin
            state_next_s = S_BLANK;
          end
        end
        S_ON: begin
          if (cnt_r == CNT_LAST) begin
            state_next_s = S_BLANK;
            cnt_next_s   = '0;
            idx_next_s   = (idx_r == IDX_LAST) ? '0 : idx_r + IDX_ONE;
            commit_s     = (idx_r == IDX_LAST);
            frame_end_s  = (idx_r == IDX_LAST);
          end else begin
            cnt_next_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_next_s = S_OFF;
          cnt_next_s   = '0;
          idx_next_s   = '0;
        end
      endcase
    end
  end

  // Host writes land in the shadow bank; the display bank only changes on commit
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shadow_r <= '{default: 5'd0};
      disp_r   <= '{default: 5'd0};
    end else begin
      if (commit_s) begin
        disp_r <= shadow_r;
      end
      if (wr_hit_s) begin
        shadow_r[wr_idx_s] <= i_wr_data;
      end
    end
  end

  // Leading-zero mask: a digit blanks only while every digit above it is blank
  always_comb begin
    lzb_mask_s  = '0;
    blank_run_s = i_lzb;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      blank_run_s   = blank_run_s && is_zero_digit(disp_r[i]);
      lzb_mask_s[i] = blank_run_s && (i != 32'sd0);
    end
  end

  // Output decode; the blanked digit keeps its COM so brightness stays uniform
  always_comb begin
    com_s = {NUM_DIGITS{COM_OFF}};
    seg_s = SEG_OFF;
    case (state_r)
      S_ON: begin
        if (i_en) begin
          com_s[idx_r] = ~COM_OFF;
          seg_s        = lzb_mask_s[idx_r] ? SEG_OFF : ~seg_hi_s;
        end else begin
          com_s = {NUM_DIGITS{COM_OFF}};
          seg_s = SEG_OFF;
        end
      end
      default: begin
        com_s = {NUM_DIGITS{COM_OFF}};
        seg_s = SEG_OFF;
      end
    endcase
  end

  // Registered pin drivers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_com        <= {NUM_DIGITS{COM_OFF}};
      o_seg        <= SEG_OFF;
      o_frame_done <= 1'b0;
    end else begin
      o_com        <= com_s;
      o_seg        <= seg_s;
      o_frame_done <= frame_end_s;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed + randomized bench for fnd_scan_controller against a cycle-count
// reference model of the scan timeline.
module tb_fnd_scan_controller;

  localparam int ND = 4;
  localparam int TD = 10;
  localparam int BC = 2;
  localparam int AW = 3;
  localparam int FRAME = TD * ND;

  logic          clk = 1'b0;
  logic          rst_n, en, lzb, wr_en;
  logic [AW-1:0] wr_addr;
  logic [4:0]    wr_data;
  logic [ND-1:0] com;
  logic [7:0]    seg;
  logic          fd;

  always #5 clk = ~clk;

  fnd_scan_controller #(
    .NUM_DIGITS (ND),
    .TICK_DIV   (TD),
    .BLANK_CYC  (BC),
    .ADDR_W     (AW)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_en         (en),
    .i_lzb        (lzb),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_com        (com),
    .o_seg        (seg),
    .o_frame_done (fd)
  );

  // Active-low glyphs for 0..F with dp off.
  logic [7:0] glyph_lo [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic [4:0]    m_shadow [ND];
  logic [4:0]    m_disp   [ND];
  bit            m_run;
  int            m_k;
  logic [ND-1:0] e_com;
  logic [7:0]    e_seg;
  logic          e_fd;
  int            checks = 0;
  int            passes = 0;
  int            fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int d);
    bit blank;
    blank = (lzb == 1'b1) && (d > 0);
    for (int j = d; j < ND; j++) begin
      if (m_disp[j] != 5'd0) blank = 1'b0;
    end
    if (blank) return 8'hFF;
    return glyph_lo[m_disp[d][3:0]] & (m_disp[d][4] ? 8'h7F : 8'hFF);
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_k   = 0;
    for (int i = 0; i < ND; i++) begin
      m_shadow[i] = 5'd0;
      m_disp[i]   = 5'd0;
    end
    e_com = '1;
    e_seg = 8'hFF;
    e_fd  = 1'b0;
  endtask

  // Expected outputs after this edge: k edges since enable, slot = (k-1)/TD.
  task automatic model_edge();
    int p, d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    e_com = '1;
    e_seg = 8'hFF;
    e_fd  = 1'b0;
    if (!en) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run  = 1'b1;
      m_k    = 0;
      m_disp = m_shadow;
    end else begin
      m_k++;
      p = (m_k - 1) % TD;
      d = ((m_k - 1) / TD) % ND;
      if (p >= BC) begin
        e_com[d] = 1'b0;
        e_seg    = exp_seg(d);
      end
      if (m_k % FRAME == 0) begin
        e_fd   = 1'b1;
        m_disp = m_shadow;
      end
    end
    if (wr_en && (wr_addr < ND)) m_shadow[wr_addr] = wr_data;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("com", com, e_com);
    check("seg", seg, e_seg);
    check("frame_done", fd, e_fd);
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [4:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic run_until_k(input int modv);
    for (int i = 0; i < 200; i++) begin
      if (m_run && (m_k % FRAME == modv)) break;
      cycle();
    end
  endtask

  initial begin
    int n;
    bit found;
    rst_n = 1'b0; en = 1'b1; lzb = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();

    // Reset held with enable high
    repeat (3) cycle();
    check("reset_com", com, 4'hF);
    check("reset_seg", seg, 8'hFF);
    check("reset_fd", fd, 1'b0);

    // First COM assertion after the blank slot
    rst_n = 1'b1;
    n = 0; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      n++;
      if (com !== 4'hF) found = 1'b1;
    end
    check("first_com_latency", n, 1 + BC + 1);
    check("first_com", com, 4'b1110);
    repeat (40) cycle();

    // Scan order with values 1..4
    en = 1'b0; cycle();
    for (int i = 0; i < ND; i++) write(AW'(i), 5'(i + 1));
    en = 1'b1;
    repeat (85) cycle();

    // Mid-frame write, then a write in the commit cycle
    run_until_k(20);
    write(3'd2, 5'd7);
    run_until_k(39);
    write(3'd1, 5'd9);
    repeat (90) cycle();

    // Leading-zero blanking, then dp un-blanks digit 3
    en = 1'b0; cycle();
    write(3'd3, 5'd0); write(3'd2, 5'd0); write(3'd1, 5'd5); write(3'd0, 5'd0);
    lzb = 1'b1; en = 1'b1;
    repeat (45) cycle();
    write(3'd3, 5'h10);
    repeat (85) cycle();

    // Abort while digit 2 is lit, then restart without a frame pulse
    run_until_k(25);
    en = 1'b0; cycle();
    check("abort_com", com, 4'hF);
    repeat (3) cycle();
    en = 1'b1;
    repeat (50) cycle();

    // Randomized writes, LZB toggles and enable drops
    for (int i = 0; i < 300; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
      if ($urandom_range(0, 40) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      cycle();
    end
    wr_en = 1'b0; en = 1'b1; lzb = 1'b0;

    // Asynchronous reset while a digit is lit
    for (int i = 0; i < 100; i++) begin
      if (m_run && m_k > 0 && ((m_k - 1) % TD) >= BC + 1 && ((m_k - 1) % TD) < TD - 1) break;
      cycle();
    end
    check("pre_reset_lit", (com !== 4'hF), 1'b1);
    #3 rst_n = 1'b0;
    #1;
    check("async_com", com, 4'hF);
    check("async_seg", seg, 8'hFF);
    check("async_fd", fd, 1'b0);
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (45) cycle();

    // Out-of-range addresses are ignored
    write(3'd5, 5'd8);
    write(3'd6, 5'd3);
    write(3'd7, 5'd1);
    repeat (90) cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
